// File: rtl/stack_unit.sv
// 8051 hardware stack: owns SP and the stack RAM, pre-increment push / post-decrement pop.
// Optional overflow/underflow guard enabled by defining STACK_GUARD_EN.
module stack_unit #(
  parameter int unsigned DEPTH    = 128,
  parameter logic [7:0]  SP_RESET = 8'h07
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_stack,
  input  logic [7:0] stack_in,
  input  logic       pop_stack,
  input  logic       sp_wr,
  input  logic [7:0] sp_wdata,
  output logic [7:0] stack_out,
  output logic [7:0] sp,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  FULL_SP = 8'(DEPTH - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    sp_q, sp_d;
  logic [7:0]    sp_inc;
  logic          we;
  logic [AW-1:0] waddr;
  logic          err_q, err_d;

  assign sp_inc      = sp_q + 8'd1;
  assign waddr       = sp_inc[AW-1:0];
  assign sp          = sp_q;
  assign stack_out   = mem_q[sp_q[AW-1:0]];
  assign stack_empty = (sp_q == SP_RESET);
  assign stack_full  = (sp_q == FULL_SP);
  assign stack_err   = err_q;

  // Priority: sp_wr > push > pop; reset is applied in the register process.
  always_comb begin
    sp_d  = sp_q;
    we    = 1'b0;
    err_d = err_q;
    if (sp_wr) begin
      sp_d  = sp_wdata;
      err_d = 1'b0;
    end else if (push_stack) begin
`ifdef STACK_GUARD_EN
      if (stack_full) begin
        err_d = 1'b1;
      end else begin
        sp_d = sp_inc;
        we   = 1'b1;
      end
      if (pop_stack) err_d = 1'b1;
`else
      sp_d = sp_inc;
      we   = 1'b1;
`endif
    end else if (pop_stack) begin
`ifdef STACK_GUARD_EN
      if (stack_empty) err_d = 1'b1;
      else             sp_d  = sp_q - 8'd1;
`else
      sp_d = sp_q - 8'd1;
`endif
    end
`ifndef STACK_GUARD_EN
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q  <= SP_RESET;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // RAM is not cleared by reset; a push coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (we && !reset) mem_q[waddr] <= stack_in;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit; popped bytes are checked via a scoreboard queue.
// Expectations follow STACK_GUARD_EN when the macro is defined for the build.
module tb_stack_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       push_stack = 1'b0;
  logic [7:0] stack_in = '0;
  logic       pop_stack = 1'b0;
  logic       sp_wr = 1'b0;
  logic [7:0] sp_wdata = '0;
  logic [7:0] stack_out;
  logic [7:0] sp;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_q [$];

  stack_unit #(.DEPTH(128), .SP_RESET(8'h07)) dut (
    .clock      (clock),
    .reset      (reset),
    .push_stack (push_stack),
    .stack_in   (stack_in),
    .pop_stack  (pop_stack),
    .sp_wr      (sp_wr),
    .sp_wdata   (sp_wdata),
    .stack_out  (stack_out),
    .sp         (sp),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .stack_err  (stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; if pop_chk, the byte on stack_out during the
  // pop cycle is compared against the head of the scoreboard.
  task automatic cyc(input logic rst, input logic psh, input logic [7:0] din,
                     input logic pop, input logic wr, input logic [7:0] wd,
                     input logic pop_chk);
    logic [7:0] e;
    @(negedge clock);
    reset = rst; push_stack = psh; stack_in = din;
    pop_stack = pop; sp_wr = wr; sp_wdata = wd;
    #1;
    if (pop_chk) begin
      if (exp_q.size() == 0) begin
        chk("pop_scoreboard_empty", 8'h01, 8'h00);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", stack_out, e);
      end
    end
    @(posedge clock);
    #1;
    reset = 1'b0; push_stack = 1'b0; pop_stack = 1'b0; sp_wr = 1'b0;
  endtask

  initial begin
    // 1. reset
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_sp", sp, 8'h07);
    chk("rst_empty", {7'd0, stack_empty}, 8'h01);
    chk("rst_full", {7'd0, stack_full}, 8'h00);
    chk("rst_err", {7'd0, stack_err}, 8'h00);

    // 2. push/push/pop/pop
    cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("push2_sp", sp, 8'h09);
    chk("push2_top", stack_out, 8'h00);
    chk("push2_empty", {7'd0, stack_empty}, 8'h00);
    exp_q.push_back(8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("pop1_sp", sp, 8'h08);
    chk("pop1_top", stack_out, 8'h3C);
    exp_q.push_back(8'h3C);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("pop2_sp", sp, 8'h07);
    chk("pop2_empty", {7'd0, stack_empty}, 8'h01);

    // 3. fill to top, then overflow
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 1'b0);
    chk("wr7e_sp", sp, 8'h7E);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("full_sp", sp, 8'h7F);
    chk("full_flag", {7'd0, stack_full}, 8'h01);
    chk("full_top", stack_out, 8'hAA);
    cyc(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef STACK_GUARD_EN
    chk("ovf_sp", sp, 8'h7F);
    chk("ovf_err", {7'd0, stack_err}, 8'h01);
    chk("ovf_top", stack_out, 8'hAA);
`else
    chk("ovf_sp", sp, 8'h80);
    chk("ovf_err", {7'd0, stack_err}, 8'h00);
    chk("ovf_mem0", stack_out, 8'hBB);
    chk("ovf_full", {7'd0, stack_full}, 8'h00);
`endif

    // 4. underflow from reset
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst2_err", {7'd0, stack_err}, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef STACK_GUARD_EN
    chk("unf_sp", sp, 8'h07);
    chk("unf_err", {7'd0, stack_err}, 8'h01);
`else
    chk("unf_sp", sp, 8'h06);
    chk("unf_empty", {7'd0, stack_empty}, 8'h00);
    chk("unf_err", {7'd0, stack_err}, 8'h00);
`endif

    // 5. push+pop collision, sp_wr dropping a push
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0);
    chk("wr08_err", {7'd0, stack_err}, 8'h00);
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("coll_sp", sp, 8'h09);
    chk("coll_top", stack_out, 8'h55);
`ifdef STACK_GUARD_EN
    chk("coll_err", {7'd0, stack_err}, 8'h01);
`else
    chk("coll_err", {7'd0, stack_err}, 8'h00);
`endif
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 1'b0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("seed21_sp", sp, 8'h21);
    cyc(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h20, 1'b0);
    chk("wrpush_sp", sp, 8'h20);
    chk("wrpush_err", {7'd0, stack_err}, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0);
    chk("wrpush_mem21", stack_out, 8'h77);

    // 6. reset during second push
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst_sp", sp, 8'h08);
    cyc(1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst_sp", sp, 8'h07);
    chk("midrst_empty", {7'd0, stack_empty}, 8'h01);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0);
    chk("midrst_mem08", stack_out, 8'h12);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h09, 1'b0);
    chk("midrst_mem09", stack_out, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
